// File: rtl/ps2_key_filter.sv
// ps2_key_filter: PS/2 scan-code filter with make/break/extended decode, key table lookup,
// pressed-key bitmap, repeat suppression, prefix timeout and saturating error count.
//   clk, reset_n      : clock, async active-low reset
//   rx_done_tick      : strobe, rx_data holds a new byte
//   clr               : sync clear of key_state and err_cnt
//   key_valid         : one-cycle event strobe, with key_idx / key_release / key_ext
//   key_state         : bit i set while table key i is held
//   invalid_tick      : one-cycle strobe for unknown code, bad prefix order or timeout
//   err_cnt           : saturating count of invalid_tick pulses
module ps2_key_filter #(
    parameter int                    NUM_KEYS        = 9,
    parameter logic [8*NUM_KEYS-1:0] KEY_TABLE       = 72'h155A3132214D261E16,
    parameter int                    IDX_W           = 4,
    parameter bit                    EXT_MODE        = 1'b0,
    parameter bit                    REPEAT_SUPPRESS = 1'b1,
    parameter int                    TIMEOUT_CYC     = 50000,
    parameter int                    ERR_W           = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx_done_tick,
    input  logic [7:0]          rx_data,
    input  logic                clr,
    output logic                key_valid,
    output logic [IDX_W-1:0]    key_idx,
    output logic                key_release,
    output logic                key_ext,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                invalid_tick,
    output logic [ERR_W-1:0]    err_cnt
);
    // bit 0 = break pending, bit 1 = extended pending
    localparam logic [1:0] IDLE = 2'd0, BRK = 2'd1, EXT = 2'd2, EXT_BRK = 2'd3;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    logic [1:0]          state, nxt_state;
    logic [TW-1:0]       tmo;
    logic                is_f0, is_e0, expire, lookup, hit, ev, inv;
    logic [IDX_W-1:0]    hit_idx;
    logic [NUM_KEYS-1:0] mask;

    assign is_f0  = rx_data == 8'hF0;
    assign is_e0  = rx_data == 8'hE0;
    // a byte in the expiry cycle takes precedence over the timeout
    assign expire = !rx_done_tick && state != IDLE && tmo == TW'(TIMEOUT_CYC - 1);
    // extended codes are only looked up when EXT_MODE enables them; otherwise dropped silently
    assign lookup = rx_done_tick && !is_f0 && !is_e0 && (EXT_MODE || !state[1]);

    // descending scan so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (rx_data == KEY_TABLE[8*i +: 8]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
    end

    assign mask = NUM_KEYS'(1) << hit_idx;
    assign ev   = lookup && hit && (state[0] || !(REPEAT_SUPPRESS && |(key_state & mask)));
    assign inv  = expire || (lookup && !hit) ||
                  (rx_done_tick && ((is_f0 && state == EXT_BRK) || (is_e0 && state[0])));

    assign nxt_state = !rx_done_tick ? (expire ? IDLE : state)
                     : is_f0         ? (state == EXT_BRK ? IDLE : state | BRK)
                     : is_e0         ? (state[0] ? IDLE : EXT)
                     : IDLE;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state        <= IDLE;
            tmo          <= '0;
            key_valid    <= 1'b0;
            key_idx      <= '0;
            key_release  <= 1'b0;
            key_ext      <= 1'b0;
            key_state    <= '0;
            invalid_tick <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state        <= nxt_state;
            tmo          <= (rx_done_tick || nxt_state == IDLE) ? '0 : tmo + TW'(1);
            key_valid    <= ev;
            invalid_tick <= inv;
            if (ev) begin
                key_idx     <= hit_idx;
                key_release <= state[0];
                key_ext     <= state[1];
            end
            key_state    <= clr ? '0 : !ev ? key_state : state[0] ? key_state & ~mask : key_state | mask;
            err_cnt      <= clr ? '0 : err_cnt + ERR_W'(inv && !(&err_cnt));
        end
endmodule
